// File: rtl/mau_pkg.sv
// Shared types for the memory access unit: access-size and FSM state enums,
// bus widths, and the helper that gives the address bits an access size must clear.
package mau_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } sizeT;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } stateT;

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] lowMask(input sizeT sz);
    logic [2:0] m;
    m = 3'b000;
    case (sz)
      SZ_B: m = 3'b000;
      SZ_H: m = 3'b001;
      SZ_W: m = 3'b011;
      SZ_D: m = 3'b111;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response bus between the multicycle controller, the memory access
// unit and the doubleword-wide synchronous memory.
interface mem_access_unit_if;
  import mau_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              misalign_exc;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_rdata,
    output req_ready, mem_addr, mem_wdata, mem_we,
    output resp_valid, resp_rdata, misalign_exc
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output mem_rdata,
    input  req_ready, mem_addr, mem_wdata, mem_we,
    input  resp_valid, resp_rdata, misalign_exc
  );

endinterface

// File: rtl/mau_lane_align.sv
// Little-endian byte-lane handling: extracts and extends load data from a
// doubleword and merges store data into a doubleword at a byte offset.
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [2:0]        offset,
  input  sizeT              size,
  input  logic              isUnsigned,
  input  logic [DATA_W-1:0] storeData,
  output logic [DATA_W-1:0] loadData,
  output logic [DATA_W-1:0] mergeData
);

  logic [5:0]        shamt;
  logic [DATA_W-1:0] shifted;
  logic [7:0]        sizeLanes;
  logic [7:0]        laneSel;
  logic [DATA_W-1:0] bitMask;
  logic              signB;
  logic              signH;
  logic              signW;

  assign shamt   = {offset, 3'b000};
  assign shifted = word >> shamt;

  assign signB = ~isUnsigned & shifted[7];
  assign signH = ~isUnsigned & shifted[15];
  assign signW = ~isUnsigned & shifted[31];

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    loadData  = shifted;
    sizeLanes = 8'hFF;
    case (size)
      SZ_B: begin
        loadData  = {{56{signB}}, shifted[7:0]};
        sizeLanes = 8'h01;
      end
      SZ_H: begin
        loadData  = {{48{signH}}, shifted[15:0]};
        sizeLanes = 8'h03;
      end
      SZ_W: begin
        loadData  = {{32{signW}}, shifted[31:0]};
        sizeLanes = 8'h0F;
      end
      SZ_D: begin
        loadData  = shifted;
        sizeLanes = 8'hFF;
      end
      default: ;
    endcase
  end

  assign laneSel = sizeLanes << offset;

  always_comb begin
    bitMask = '0;
    for (int i = 0; i < 8; i++) begin
      bitMask[8*i +: 8] = {8{laneSel[i]}};
    end
  end

  // Untouched lanes keep the value read back during the RMW.
  assign mergeData = (word & ~bitMask) | ((storeData << shamt) & bitMask);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit in front of a doubleword-aligned synchronous memory.
// Optional feature macro: MAU_MISALIGN_CHECK_EN (trap misaligned accesses).
module mem_access_unit
  import mau_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  mem_access_unit_if.slave   bus
);

  stateT             state;
  stateT             nextState;

  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;
  logic [DATA_W-1:0] rdBuf;
  logic [DATA_W-1:0] respRdataQ;
  sizeT              sizeQ;
  logic              writeQ;
  logic              unsQ;

  sizeT              reqSize;
  logic              accept;
  logic              reqMisaligned;
  logic [ADDR_W-1:0] reqAddrUse;
  logic [ADDR_W-1:0] alignedAddr;

  logic [DATA_W-1:0] alignWord;
  logic [DATA_W-1:0] loadData;
  logic [DATA_W-1:0] mergeData;

  logic              reqReady;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic              respValid;

  assign reqSize     = sizeT'(bus.req_size);
  assign accept      = bus.req_valid && (state == IDLE);
  assign alignedAddr = {addrQ[ADDR_W-1:3], 3'b000};

`ifdef MAU_MISALIGN_CHECK_EN
  logic misQ;
  assign reqMisaligned = |(bus.req_addr[2:0] & lowMask(reqSize));
  assign reqAddrUse    = bus.req_addr;
`else
  // Without the trap, sub-size address bits are simply dropped.
  assign reqMisaligned = 1'b0;
  assign reqAddrUse    = {bus.req_addr[ADDR_W-1:3], bus.req_addr[2:0] & ~lowMask(reqSize)};
`endif

  // Loads extract straight from memory in CAP; the RMW merge uses the buffer.
  assign alignWord = (state == CAP) ? bus.mem_rdata : rdBuf;

  mau_lane_align u_lane_align (
    .word       (alignWord),
    .offset     (addrQ[2:0]),
    .size       (sizeQ),
    .isUnsigned (unsQ),
    .storeData  (wdataQ),
    .loadData   (loadData),
    .mergeData  (mergeData)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    reqReady  = 1'b0;
    memWe     = 1'b0;
    memAddr   = '0;
    memWdata  = '0;
    respValid = 1'b0;
    case (state)
      IDLE: begin
        reqReady = 1'b1;
        if (accept) begin
          if (reqMisaligned)                      nextState = RESP;
          else if (bus.req_write && reqSize == SZ_D) nextState = WR;
          else                                    nextState = RD;
        end
      end
      RD: begin
        memAddr   = alignedAddr;
        nextState = CAP;
      end
      CAP: begin
        nextState = writeQ ? WR : RESP;
      end
      WR: begin
        memWe     = 1'b1;
        memAddr   = alignedAddr;
        memWdata  = mergeData;
        nextState = RESP;
      end
      RESP: begin
        respValid = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addrQ      <= '0;
      wdataQ     <= '0;
      rdBuf      <= '0;
      respRdataQ <= '0;
      sizeQ      <= SZ_B;
      writeQ     <= 1'b0;
      unsQ       <= 1'b0;
`ifdef MAU_MISALIGN_CHECK_EN
      misQ       <= 1'b0;
`endif
    end else begin
      if (accept) begin
        addrQ  <= reqAddrUse;
        wdataQ <= bus.req_wdata;
        sizeQ  <= reqSize;
        writeQ <= bus.req_write;
        unsQ   <= bus.req_unsigned;
`ifdef MAU_MISALIGN_CHECK_EN
        misQ   <= reqMisaligned;
`endif
      end
      if (state == CAP) begin
        rdBuf <= bus.mem_rdata;
        if (!writeQ) respRdataQ <= loadData;
      end
    end
  end

  assign bus.req_ready  = reqReady;
  assign bus.mem_we     = memWe;
  assign bus.mem_addr   = memAddr;
  assign bus.mem_wdata  = memWdata;
  assign bus.resp_valid = respValid;
  assign bus.resp_rdata = respRdataQ;

`ifdef MAU_MISALIGN_CHECK_EN
  assign bus.misalign_exc = (state == RESP) && misQ;
`else
  assign bus.misalign_exc = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a driver queues expected responses and
// writes, and negedge monitors pop and compare them against the DUT.
module tb_mem_access_unit;
  import mau_pkg::*;

  typedef struct {
    string       tag;
    logic [63:0] rdata;
    logic        mis;
    int          lat;
    int          acc;
  } respT;

  typedef struct {
    string       tag;
    logic [63:0] addr;
    logic [63:0] data;
    int          lat;
    int          acc;
  } wrT;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;

  respT expQ[$];
  wrT   wrQ[$];

  logic [63:0] mem [0:255];

  mem_access_unit_if bus();

  mem_access_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read data appears the cycle after the address is sampled.
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[10:3]] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr[10:3]];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.resp_valid) begin
        if (expQ.size() == 0) begin
          check("unexpected resp_valid", bus.resp_valid, 64'd0);
        end else begin
          respT e;
          e = expQ.pop_front();
          check({e.tag, " resp_rdata"}, bus.resp_rdata, e.rdata);
          check({e.tag, " misalign_exc"}, bus.misalign_exc, e.mis);
          check({e.tag, " resp latency"}, cyc - e.acc, e.lat);
        end
      end
      if (bus.mem_we) begin
        if (wrQ.size() == 0) begin
          check("unexpected mem_we", bus.mem_we, 64'd0);
        end else begin
          wrT w;
          w = wrQ.pop_front();
          check({w.tag, " mem_addr"}, bus.mem_addr, w.addr);
          check({w.tag, " mem_wdata"}, bus.mem_wdata, w.data);
          check({w.tag, " write latency"}, cyc - w.acc, w.lat);
        end
      end
    end
  end

  task automatic doReq(input string tag, input bit w, input logic [1:0] sz, input bit u,
                       input logic [63:0] a, input logic [63:0] wd,
                       input bit hasResp, input logic [63:0] rd, input bit mis, input int rlat,
                       input bit hasWr, input logic [63:0] wa, input logic [63:0] wdat,
                       input int wlat, input bit poke);
    int   n;
    respT r;
    wrT   x;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      check({tag, " req_ready timeout"}, bus.req_ready, 64'd1);
      return;
    end
    bus.req_write    = w;
    bus.req_size     = sz;
    bus.req_unsigned = u;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    bus.req_valid    = 1'b1;
    if (hasResp) begin
      r = '{tag: tag, rdata: rd, mis: mis, lat: rlat, acc: cyc};
      expQ.push_back(r);
    end
    if (hasWr) begin
      x = '{tag: tag, addr: wa, data: wdat, lat: wlat, acc: cyc};
      wrQ.push_back(x);
    end
    @(posedge clk);
    #1;
    if (poke) begin
      // A request held while busy must be dropped, not queued.
      bus.req_write = 1'b1;
      bus.req_size  = 2'd3;
      bus.req_addr  = 64'h300;
      bus.req_wdata = 64'h0;
      repeat (2) @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic load(input string tag, input logic [1:0] sz, input bit u,
                      input logic [63:0] a, input logic [63:0] exp);
    doReq(tag, 1'b0, sz, u, a, 64'h0, 1'b1, exp, 1'b0, 3, 1'b0, 64'h0, 64'h0, 0, 1'b0);
  endtask

  task automatic store(input string tag, input logic [1:0] sz, input logic [63:0] a,
                       input logic [63:0] wd, input logic [63:0] wdat,
                       input logic [63:0] lastLoad);
    int wl;
    wl = (sz == 2'd3) ? 1 : 3;
    doReq(tag, 1'b1, sz, 1'b0, a, wd, 1'b1, lastLoad, 1'b0, wl + 1,
          1'b1, {a[63:3], 3'b000}, wdat, wl, 1'b0);
  endtask

`ifdef MAU_MISALIGN_CHECK_EN
  localparam logic [63:0] LW102_RES = 64'h1122_AA44_5566_7788;
`else
  localparam logic [63:0] LW102_RES = 64'h0000_0000_5566_7788;
`endif

  initial begin
    int n;
    cyc      = 0;
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) mem[i] = 64'h0;
    mem[8'h20] = 64'h0000_0000_80FF_0000;   // 0x100
    mem[8'h60] = 64'h0102_0304_0506_0708;   // 0x300

    reset            = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 64'h0;
    bus.req_wdata    = 64'h0;

    repeat (2) @(negedge clk);
    check("reset req_ready",    bus.req_ready,    64'd1);
    check("reset mem_we",       bus.mem_we,       64'd0);
    check("reset mem_addr",     bus.mem_addr,     64'd0);
    check("reset mem_wdata",    bus.mem_wdata,    64'd0);
    check("reset resp_valid",   bus.resp_valid,   64'd0);
    check("reset resp_rdata",   bus.resp_rdata,   64'd0);
    check("reset misalign_exc", bus.misalign_exc, 64'd0);
    reset = 1'b0;

    load("lb 0x103", SZ_B, 1'b0, 64'h103, 64'hFFFF_FFFF_FFFF_FF80);
    doReq("lhu 0x102 busy-poke", 1'b0, SZ_H, 1'b1, 64'h102, 64'h0,
          1'b1, 64'h0000_0000_0000_80FF, 1'b0, 3, 1'b0, 64'h0, 64'h0, 0, 1'b1);
    store("sd 0x100", SZ_D, 64'h100, 64'h1122_3344_5566_7788,
          64'h1122_3344_5566_7788, 64'h0000_0000_0000_80FF);
    store("sb 0x105", SZ_B, 64'h105, 64'hFFFF_FFFF_FFFF_FFAA,
          64'h1122_AA44_5566_7788, 64'h0000_0000_0000_80FF);
    load("ld 0x100", SZ_D, 1'b0, 64'h100, 64'h1122_AA44_5566_7788);
`ifdef MAU_MISALIGN_CHECK_EN
    doReq("lw 0x102 misaligned", 1'b0, SZ_W, 1'b0, 64'h102, 64'h0,
          1'b1, LW102_RES, 1'b1, 1, 1'b0, 64'h0, 64'h0, 0, 1'b0);
`else
    load("lw 0x102 cleared", SZ_W, 1'b0, 64'h102, LW102_RES);
`endif
    store("sd 0x200", SZ_D, 64'h200, 64'hDEAD_BEEF_0123_4567,
          64'hDEAD_BEEF_0123_4567, LW102_RES);
    load("lw 0x204",  SZ_W, 1'b0, 64'h204, 64'hFFFF_FFFF_DEAD_BEEF);
    load("lwu 0x204", SZ_W, 1'b1, 64'h204, 64'h0000_0000_DEAD_BEEF);
    store("sh 0x206", SZ_H, 64'h206, 64'h0000_0000_0000_BEEF,
          64'hBEEF_BEEF_0123_4567, 64'h0000_0000_DEAD_BEEF);
    load("ld unsigned 0x200", SZ_D, 1'b1, 64'h200, 64'hBEEF_BEEF_0123_4567);
    load("lbu 0x207", SZ_B, 1'b1, 64'h207, 64'h0000_0000_0000_00BE);
    load("lb 0x201",  SZ_B, 1'b0, 64'h201, 64'h0000_0000_0000_0045);
    load("lh 0x206",  SZ_H, 1'b0, 64'h206, 64'hFFFF_FFFF_FFFF_BEEF);
    store("sw 0x20C", SZ_W, 64'h20C, 64'h0000_0000_CAFE_F00D,
          64'hCAFE_F00D_0000_0000, 64'hFFFF_FFFF_FFFF_BEEF);
    load("lw 0x20C",  SZ_W, 1'b0, 64'h20C, 64'hFFFF_FFFF_CAFE_F00D);

    // Reset in the WR cycle of a half store: write strobe must drop at once.
    doReq("sh 0x302 reset-in-WR", 1'b1, SZ_H, 1'b0, 64'h302, 64'h0000_0000_0000_9999,
          1'b0, 64'h0, 1'b0, 0, 1'b1, 64'h300, 64'h0102_0304_9999_0708, 3, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.mem_we && n < 20);
    check("sh reached WR", bus.mem_we, 64'd1);
    #2 reset = 1'b1;
    #1;
    check("mid-op reset mem_we",     bus.mem_we,     64'd0);
    check("mid-op reset mem_addr",   bus.mem_addr,   64'd0);
    check("mid-op reset req_ready",  bus.req_ready,  64'd1);
    check("mid-op reset resp_valid", bus.resp_valid, 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("mid-op reset resp_rdata", bus.resp_rdata, 64'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("abandoned store left memory", mem[8'h60], 64'h0102_0304_0506_0708);

    store("sb 0x301 after reset", SZ_B, 64'h301, 64'h0000_0000_0000_0055,
          64'h0102_0304_0506_5508, 64'h0);
    load("lw 0x300 after reset", SZ_W, 1'b0, 64'h300, 64'h0000_0000_0506_5508);

    n = 0;
    while ((expQ.size() != 0 || wrQ.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("pending responses", expQ.size(), 64'd0);
    check("pending writes",    wrQ.size(),  64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
